// File: rtl/mem_master.sv
// Initiator-side controller for the single-port synchronous RAM: accepts word
// write / read-burst requests and returns read data after the RAM's two-edge latency.
module mem_master #(
    parameter int DATA_WIDTH = 12,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        READ_ISSUE = 2'd2,
        READ_DRAIN = 2'd3
    } state_t;

    state_t                 state_r;
    logic [LEN_WIDTH-1:0]   count_r;
    logic [1:0]             pipe_valid_r;
    logic [1:0]             pipe_last_r;
    logic                   busy_r;
    logic                   issue_s;
    logic                   issue_last_s;

    // Ready is gated by rst_n so nothing is taken while reset is being sampled.
    assign req_ready = (state_r == IDLE) && rst_n;
    assign busy      = busy_r;
    assign rsp_valid = pipe_valid_r[1];
    assign rsp_last  = pipe_last_r[1];
    assign rsp_data  = mem_data_out;

    // Flags for the address being presented to the RAM this cycle.
    always_comb begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        if (state_r == READ_ISSUE) begin
            issue_s      = 1'b1;
            issue_last_s = (count_r == '0);
        end else begin
            issue_s      = 1'b0;
            issue_last_s = 1'b0;
        end
    end

    // Request FSM, RAM pin registers and the two-stage response tracker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            busy_r           <= 1'b0;
            count_r          <= '0;
            pipe_valid_r     <= 2'b00;
            pipe_last_r      <= 2'b00;
            mem_addr         <= '0;
            mem_data_in      <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            pipe_valid_r <= {pipe_valid_r[0], issue_s};
            pipe_last_r  <= {pipe_last_r[0], issue_last_s};
            case (state_r)
                IDLE: begin
                    mem_write_enable <= 1'b0;
                    if (req_valid) begin
                        mem_addr <= req_addr;
                        busy_r   <= 1'b1;
                        if (req_write) begin
                            mem_data_in      <= req_wdata;
                            mem_write_enable <= 1'b1;
                            state_r          <= WRITE;
                        end else begin
                            count_r <= req_len;
                            state_r <= READ_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    busy_r           <= 1'b0;
                    state_r          <= IDLE;
                end
                READ_ISSUE: begin
                    // The final address stays on the bus through the drain.
                    if (count_r == '0) begin
                        state_r <= READ_DRAIN;
                    end else begin
                        mem_addr <= mem_addr + DATA_WIDTH'(1);
                        count_r  <= count_r - LEN_WIDTH'(1);
                    end
                end
                READ_DRAIN: begin
                    if (pipe_last_r[1]) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    mem_write_enable <= 1'b0;
                    busy_r           <= 1'b0;
                    state_r          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: a 4096-word two-edge-latency RAM model, a request table
// with valid held back-to-back, a scoreboard of beats and bus cycles, and a mid-burst reset.
module tb_mem_master;
    localparam int DW = 12;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [DW-1:0] req_addr, req_wdata;
    logic [LW-1:0] req_len;
    logic          rsp_valid, rsp_last, busy;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] mem_addr, mem_data_in, mem_data_out;
    logic          mem_write_enable;

    mem_master #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
        .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write on the edge ending the write cycle, read data two edges later.
    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] ram_q1;
    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_addr] <= mem_data_in;
        ram_q1       <= ram[mem_addr];
        mem_data_out <= ram_q1;
    end

    typedef struct {
        bit          wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
        logic [LW-1:0] len;
        int          gap;     // expected cycles from acceptance until req_ready returns
    } vec_t;

    typedef struct { int cyc; logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int cyc; logic [DW-1:0] addr; logic [DW-1:0] data; logic we; } bus_t;

    beat_t         rsp_q[$];
    bus_t          bus_q[$];
    logic [DW-1:0] shadow [0:4095];
    int            checks = 0;
    int            errors = 0;
    int            free_cyc = 0;
    int            last_c0 = 0;
    vec_t          vt [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: response beats and per-cycle RAM pin expectations.
    always @(negedge clk) begin : monitor
        beat_t b;
        bus_t  e;
        logic  exp_we;
        if (rst_n) begin
            while (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
                b = rsp_q.pop_front();
                chk("rsp_missing_beat", 32'(0), 32'(1));
            end
            while (bus_q.size() != 0 && bus_q[0].cyc < cyc) begin
                e = bus_q.pop_front();
                chk("bus_missed_cycle", 32'(0), 32'(1));
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(1), 32'(0));
                end else if (rsp_q[0].cyc == cyc) begin
                    b = rsp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(b.data));
                    chk("rsp_last", 32'(rsp_last), 32'(b.last));
                end else begin
                    chk("rsp_early", 32'(cyc), 32'(rsp_q[0].cyc));
                end
            end else begin
                chk("rsp_last_alone", 32'(rsp_last), 32'(0));
            end
            exp_we = 1'b0;
            if (bus_q.size() != 0 && bus_q[0].cyc == cyc) begin
                e = bus_q.pop_front();
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) chk("mem_data_in", 32'(mem_data_in), 32'(e.data));
                exp_we = e.we;
            end
            chk("mem_write_enable", 32'(mem_write_enable), 32'(exp_we));
            if (mem_write_enable) chk("we_during_read", 32'(rsp_q.size()), 32'(0));
        end
    end

    // Present one request with req_valid held; waits for acceptance and queues expectations.
    task automatic present(input vec_t v);
        int            waited = 0;
        bit            timed_out = 1'b0;
        logic [DW-1:0] a;
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.data;
        req_len   = v.len;
        #1;
        while (1'b1) begin
            chk("req_ready", 32'(req_ready), 32'(cyc >= free_cyc));
            if (req_ready) break;
            if (waited >= 64) begin
                timed_out = 1'b1;
                chk("accept_timeout", 32'(0), 32'(1));
                break;
            end
            @(negedge clk); #1;
            waited++;
        end
        if (!timed_out) begin
            last_c0 = cyc;
            if (v.wr) begin
                shadow[v.addr] = v.data;
                bus_q.push_back('{cyc + 1, v.addr, v.data, 1'b1});
            end else begin
                for (int k = 0; k <= int'(v.len); k++) begin
                    a = v.addr + DW'(k);
                    bus_q.push_back('{cyc + 1 + k, a, 12'h000, 1'b0});
                    rsp_q.push_back('{cyc + 3 + k, shadow[a], k == int'(v.len)});
                end
            end
            free_cyc = cyc + v.gap;
            @(negedge clk); #1;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_pending", 32'(rsp_q.size() + bus_q.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_data_in"}, 32'(mem_data_in), 32'(0));
        chk({tag, "_mem_we"}, 32'(mem_write_enable), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = DW'(i * 7 + 3);
            shadow[i] = DW'(i * 7 + 3);
        end
        vt[0]  = '{1'b1, 12'h005, 12'hABC, 4'd0,  2};
        vt[1]  = '{1'b0, 12'h005, 12'h000, 4'd0,  4};
        vt[2]  = '{1'b1, 12'h010, 12'h100, 4'd0,  2};
        vt[3]  = '{1'b1, 12'h011, 12'h101, 4'd0,  2};
        vt[4]  = '{1'b1, 12'h012, 12'h102, 4'd0,  2};
        vt[5]  = '{1'b1, 12'h013, 12'h103, 4'd0,  2};
        vt[6]  = '{1'b0, 12'h010, 12'h000, 4'd3,  7};
        vt[7]  = '{1'b1, 12'hFFF, 12'h7E1, 4'd0,  2};
        vt[8]  = '{1'b0, 12'hFFE, 12'h000, 4'd3,  7};
        vt[9]  = '{1'b0, 12'h020, 12'h000, 4'd15, 19};
        vt[10] = '{1'b1, 12'h000, 12'h123, 4'd0,  2};
        vt[11] = '{1'b0, 12'hFFF, 12'h000, 4'd1,  5};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_len = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        #1;
        free_cyc = cyc;

        // Whole table back-to-back with req_valid never dropped.
        for (int i = 0; i < 12; i++) present(vt[i]);
        req_valid = 1'b0;
        drain();

        // Reset for one cycle while beat 2 of a len-7 burst is on the response port.
        present('{1'b0, 12'h040, 12'h000, 4'd7, 11});
        req_valid = 1'b0;
        while (cyc < last_c0 + 5) begin @(negedge clk); #1; end
        while (rsp_q.size() != 0 && rsp_q[rsp_q.size()-1].cyc > cyc) void'(rsp_q.pop_back());
        while (bus_q.size() != 0 && bus_q[bus_q.size()-1].cyc > cyc) void'(bus_q.pop_back());
        rst_n = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'(1));
        free_cyc = cyc;
        present('{1'b0, 12'h005, 12'h000, 4'd0, 4});
        req_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
